// File: rtl/main_datapath.sv
// ----------------------------------------------------------------------------
// main_datapath
//   Single-cycle load/store execution core: a 32x32 register file, an 8-op
//   ALU and a word-addressed data memory. The effective address is
//   R[RS] op sign_ext(offset). A load writes the addressed memory word into
//   R[W_Addr]. A store writes R[RT] into the addressed memory word.
//
// Parameters
//   MEM_AW     data memory word-address width (2**MEM_AW words)
//
// Ports
//   clk        in   1   single clock, all state updates on posedge
//   Reset      in   1   synchronous, active-low reset
//   Write_Reg  in   1   register-file write enable (R[W_Addr] <= Data_Bus)
//   Mem_Write  in   1   data-memory write enable (mem[index] <= R[RT])
//   offset     in   16  immediate, sign-extended as ALU operand B
//   ALU_OP     in   3   0 AND,1 OR,2 XOR,3 NOR,4 ADD,5 SUB,6 SLT,7 SLL
//   W_Addr     in   5   register-file write address
//   RS         in   5   read port A address (base register)
//   RT         in   5   read port B address (store data)
//   A          out  32  R[RS], combinational
//   Data_Bus   out  32  memory word addressed by Result, combinational
//   Result     out  32  ALU result
//   OF         out  1   signed overflow of ADD/SUB, 0 otherwise
//   ZF         out  1   Result == 0
//
// Configuration macro
//   OVF_WRITE_BLOCK_EN  defined: both write enables are suppressed in any
//                       cycle where OF=1. Undefined: enables act regardless.
// ----------------------------------------------------------------------------
module main_datapath #(
  parameter int MEM_AW = 6
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Write_Reg,
  input  logic        Mem_Write,
  input  logic [15:0] offset,
  input  logic [2:0]  ALU_OP,
  input  logic [4:0]  W_Addr,
  input  logic [4:0]  RS,
  input  logic [4:0]  RT,
  output logic [31:0] A,
  output logic [31:0] Data_Bus,
  output logic [31:0] Result,
  output logic        OF,
  output logic        ZF
);

  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_SLT = 3'd6,
    OP_SLL = 3'd7
  } alu_op_e;

  logic signed [DATA_W-1:0] rf_q  [32];
  logic signed [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] rt_data;
  logic signed [DATA_W-1:0] alu_res;
  logic                     alu_of;
  logic [MEM_AW-1:0]        mem_idx;
  logic                     reg_we_d;
  logic                     mem_we_d;

  function automatic logic signed [DATA_W-1:0] sign_ext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  // Returns {overflow, result}. Overflow uses a one-bit sign extension:
  // the two top bits of the widened sum disagree exactly on signed overflow.
  function automatic logic [DATA_W:0] alu_eval(input alu_op_e op,
                                               input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0]   wide;
    logic signed [DATA_W-1:0] res;
    logic                     ovf;
    wide = '0;
    res  = '0;
    ovf  = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_ADD: begin
        wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        res  = wide[DATA_W-1:0];
        ovf  = wide[DATA_W] ^ wide[DATA_W-1];
      end
      OP_SUB: begin
        wide = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        res  = wide[DATA_W-1:0];
        ovf  = wide[DATA_W] ^ wide[DATA_W-1];
      end
      OP_SLT: res = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLL: res = a << b[4:0];
      default: res = '0;
    endcase
    return {ovf, res};
  endfunction

  // R0 is hard-wired to zero on both read ports.
  assign op_a    = (RS == 5'd0) ? '0 : rf_q[RS];
  assign rt_data = (RT == 5'd0) ? '0 : rf_q[RT];
  assign op_b    = sign_ext16(offset);

  always_comb begin
    {alu_of, alu_res} = alu_eval(alu_op_e'(ALU_OP), op_a, op_b);
  end

  // Byte address -> word index; low two bits and bits above the memory
  // range are dropped, so addresses wrap around the memory.
  assign mem_idx = alu_res[MEM_AW+1:2];

  assign A        = op_a;
  assign Result   = alu_res;
  assign Data_Bus = mem_q[mem_idx];
  assign OF       = alu_of;
  assign ZF       = (alu_res == '0);

`ifdef OVF_WRITE_BLOCK_EN
  assign reg_we_d = Write_Reg & ~alu_of;
  assign mem_we_d = Mem_Write & ~alu_of;
`else
  assign reg_we_d = Write_Reg;
  assign mem_we_d = Mem_Write;
`endif

  // Both writes sample pre-edge values: the register takes the old memory
  // word and the memory takes the old R[RT], so a combined load/store is a
  // clean swap with no bypass in either direction. Reset wins over writes.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      if (reg_we_d && (W_Addr != 5'd0)) begin
        rf_q[W_Addr] <= Data_Bus;
      end
      if (mem_we_d) begin
        mem_q[mem_idx] <= rt_data;
      end
    end
  end

endmodule

// File: tb/tb_main_datapath.sv
// ----------------------------------------------------------------------------
// tb_main_datapath
//   Directed bench for main_datapath. Every step drives one operation,
//   pushes the reference model's expected outputs onto a scoreboard queue,
//   then pops and compares them against the DUT before the clock edge.
//   The model state (registers, memory) is updated at the edge.
// ----------------------------------------------------------------------------
module tb_main_datapath;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Write_Reg = 1'b0;
  logic        Mem_Write = 1'b0;
  logic [15:0] offset = '0;
  logic [2:0]  ALU_OP = 3'd4;
  logic [4:0]  W_Addr = '0;
  logic [4:0]  RS = '0;
  logic [4:0]  RT = '0;
  logic [31:0] A;
  logic [31:0] Data_Bus;
  logic [31:0] Result;
  logic        OF;
  logic        ZF;

  main_datapath #(.MEM_AW(6)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Write_Reg (Write_Reg),
    .Mem_Write (Mem_Write),
    .offset    (offset),
    .ALU_OP    (ALU_OP),
    .W_Addr    (W_Addr),
    .RS        (RS),
    .RT        (RT),
    .A         (A),
    .Data_Bus  (Data_Bus),
    .Result    (Result),
    .OF        (OF),
    .ZF        (ZF)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a << b[4:0];
    endcase
  endfunction

  // Sign-rule overflow: operands of (effectively) equal sign, result sign differs.
  function automatic logic ref_of(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] r);
    if (op == 3'd4) return (a[31] == b[31]) && (r[31] != a[31]);
    if (op == 3'd5) return (a[31] != b[31]) && (r[31] != a[31]);
    return 1'b0;
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic wr, input logic mw);
    Reset     = 1'b0;
    Write_Reg = wr;
    Mem_Write = mw;
    W_Addr    = 5'd5;
    RT        = 5'd0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'(i);
    #1;
    Reset     = 1'b1;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
  endtask

  // One single-cycle operation: drive, predict, compare, then clock it.
  task automatic apply(input string name, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wa, input logic [15:0] off,
                       input logic [2:0] op, input logic wr, input logic mw);
    logic [31:0] a_e, b_e, r_e, db_e, rt_e;
    logic        of_e;
    logic [5:0]  idx;
    RS = rs; RT = rt; W_Addr = wa; offset = off; ALU_OP = op;
    Write_Reg = wr; Mem_Write = mw;
    #1;
    a_e  = (rs == 5'd0) ? 32'd0 : m_reg[rs];
    b_e  = {{16{off[15]}}, off};
    r_e  = ref_alu(op, a_e, b_e);
    of_e = ref_of(op, a_e, b_e, r_e);
    idx  = r_e[7:2];
    db_e = m_mem[idx];
    rt_e = (rt == 5'd0) ? 32'd0 : m_reg[rt];
    push({name, "_A"}, a_e);
    push({name, "_Result"}, r_e);
    push({name, "_Data_Bus"}, db_e);
    push({name, "_OF"}, {31'd0, of_e});
    push({name, "_ZF"}, {31'd0, (r_e == 32'd0)});
    pop_check(A);
    pop_check(Result);
    pop_check(Data_Bus);
    pop_check({31'd0, OF});
    pop_check({31'd0, ZF});
    @(posedge clk);
`ifdef OVF_WRITE_BLOCK_EN
    if (!of_e) begin
`else
    begin
`endif
      if (wr && wa != 5'd0) m_reg[wa] = db_e;
      if (mw) m_mem[idx] = rt_e;
    end
    #1;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // Reset state: every register reads zero.
    for (int r = 0; r < 32; r++) apply("rst_read", 5'(r), 5'd0, 5'd0, 16'd0, 3'd4, 1'b0, 1'b0);
    RS = 5'd0; offset = 16'd8; ALU_OP = 3'd4; #1;
    check_const("rst_res8", Result, 32'd8);
    check_const("rst_db8", Data_Bus, 32'd2);

    // lw R1,[R0+4]
    apply("lw_r1", 5'd0, 5'd0, 5'd1, 16'd4, 3'd4, 1'b1, 1'b0);
    RS = 5'd1; #1;
    check_const("r1_is_1", A, 32'd1);

    // sw R1,[R1+4]
    apply("sw_r1", 5'd1, 5'd1, 5'd0, 16'd4, 3'd4, 1'b0, 1'b1);
    RS = 5'd1; offset = 16'd4; ALU_OP = 3'd4; #1;
    check_const("sw_res5", Result, 32'd5);
    check_const("sw_db1", Data_Bus, 32'd1);

    // lw R2,[R1+8]; then a write aimed at R0 must be dropped.
    apply("lw_r2", 5'd1, 5'd0, 5'd2, 16'd8, 3'd4, 1'b1, 1'b0);
    RS = 5'd2; #1;
    check_const("r2_is_2", A, 32'd2);
    apply("w_r0", 5'd1, 5'd0, 5'd0, 16'd8, 3'd4, 1'b1, 1'b0);
    RS = 5'd0; #1;
    check_const("r0_zero", A, 32'd0);

    // ALU with negative immediate.
    apply("sub_neg", 5'd1, 5'd0, 5'd0, 16'hFFFF, 3'd5, 1'b0, 1'b0);
    apply("add_zero", 5'd1, 5'd0, 5'd0, 16'hFFFF, 3'd4, 1'b0, 1'b0);
    RS = 5'd1; offset = 16'hFFFF; ALU_OP = 3'd4; #1;
    check_const("add_zf", {31'd0, ZF}, 32'd1);
    apply("slt_neg", 5'd1, 5'd0, 5'd0, 16'hFFFF, 3'd6, 1'b0, 1'b0);

    // All eight ops over two operand pairs.
    for (int op = 0; op < 8; op++) begin
      apply("op_sweep_a", 5'd2, 5'd0, 5'd0, 16'h8003, 3'(op), 1'b0, 1'b0);
      apply("op_sweep_b", 5'd1, 5'd0, 5'd0, 16'h0005, 3'(op), 1'b0, 1'b0);
    end
    RS = 5'd2; offset = 16'd3; ALU_OP = 3'd7; #1;
    check_const("sll_2_by_3", Result, 32'd16);

    // Combined load/store: R3 gets old mem[2]=2, mem[2] gets R1=1.
    apply("swap", 5'd1, 5'd1, 5'd3, 16'd8, 3'd4, 1'b1, 1'b1);
    RS = 5'd3; #1;
    check_const("swap_reg", A, 32'd2);
    RS = 5'd0; offset = 16'd8; ALU_OP = 3'd4; #1;
    check_const("swap_mem", Data_Bus, 32'd1);

    // No bypass: R4 read in its own write cycle shows the old value.
    apply("nobypass", 5'd4, 5'd0, 5'd4, 16'd12, 3'd4, 1'b1, 1'b0);
    apply("after_wr", 5'd4, 5'd0, 5'd0, 16'd0, 3'd4, 1'b0, 1'b0);

    // Address wrap: byte 256+12 and low bits 2'b11 map to word 3.
    apply("wrap", 5'd0, 5'd0, 5'd6, 16'h010F, 3'd4, 1'b1, 1'b0);
    RS = 5'd6; #1;
    check_const("wrap_r6", A, 32'd3);

    // The reset image plus load/store moves only values 0..63, so ADD/SUB
    // overflow is not reachable from the ports; check OF stays low at the
    // extremes of the immediate range instead.
    apply("of_add_max", 5'd6, 5'd0, 5'd0, 16'h7FFF, 3'd4, 1'b0, 1'b0);
    apply("of_sub_min", 5'd6, 5'd0, 5'd0, 16'h8000, 3'd5, 1'b0, 1'b0);

    // Reset with writes asserted: reset wins, state returns to the image.
    do_reset(1'b1, 1'b1);
    apply("rst2_r1", 5'd1, 5'd0, 5'd0, 16'd8, 3'd4, 1'b0, 1'b0);
    apply("rst2_r5", 5'd5, 5'd0, 5'd0, 16'd4, 3'd4, 1'b0, 1'b0);
    RS = 5'd0; offset = 16'd8; ALU_OP = 3'd4; #1;
    check_const("rst2_mem2", Data_Bus, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
